// File: rtl/prga.sv
// ARC4 pseudo-random generation and decrypt engine: walks a length-prefixed
// ciphertext, swaps S entries in place and writes the length-prefixed plaintext.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic       rdy_o,
  output logic [7:0] s_addr_o,
  input  logic [7:0] s_rddata_i,
  output logic [7:0] s_wrdata_o,
  output logic       s_wren_o,
  output logic [7:0] ct_addr_o,
  input  logic [7:0] ct_rddata_i,
  output logic [7:0] pt_addr_o,
  output logic [7:0] pt_wrdata_o,
  output logic       pt_wren_o
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    RD_SI,
    RD_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    XOR_ST
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] len_q, len_d;
  logic [7:0] jNew;

  assign jNew = j_q + s_rddata_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      len_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      len_q   <= len_d;
    end
  end

  // sj is captured before either swap write, so i==j writes the same value back
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    len_d       = len_q;
    rdy_o       = 1'b0;
    s_addr_o    = 8'd0;
    s_wrdata_o  = 8'd0;
    s_wren_o    = 1'b0;
    ct_addr_o   = 8'd0;
    pt_addr_o   = 8'd0;
    pt_wrdata_o = 8'd0;
    pt_wren_o   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy_o = 1'b1;
        if (en_i) begin
          j_d     = 8'd0;
          state_d = LEN;
        end
      end
      LEN: begin
        len_d       = ct_rddata_i;
        pt_addr_o   = 8'd0;
        pt_wrdata_o = ct_rddata_i;
        pt_wren_o   = 1'b1;
        if (ct_rddata_i == 8'd0) begin
          state_d = IDLE;
        end else begin
          i_d     = 8'd1;
          state_d = RD_SI;
        end
      end
      RD_SI: begin
        s_addr_o = i_q;
        state_d  = RD_SJ;
      end
      RD_SJ: begin
        si_d     = s_rddata_i;
        j_d      = jNew;
        s_addr_o = jNew;
        state_d  = WR_SI;
      end
      WR_SI: begin
        sj_d       = s_rddata_i;
        s_addr_o   = j_q;
        s_wrdata_o = si_q;
        s_wren_o   = 1'b1;
        state_d    = WR_SJ;
      end
      WR_SJ: begin
        s_addr_o   = i_q;
        s_wrdata_o = sj_q;
        s_wren_o   = 1'b1;
        state_d    = RD_PAD;
      end
      RD_PAD: begin
        s_addr_o  = si_q + sj_q;
        ct_addr_o = i_q;
        state_d   = XOR_ST;
      end
      XOR_ST: begin
        pt_addr_o   = i_q;
        pt_wrdata_o = s_rddata_i ^ ct_rddata_i;
        pt_wren_o   = 1'b1;
        if (i_q == len_q) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = RD_SI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
